// File: rtl/result_streamer.sv
// Drains an n x n result matrix row-major as a strobe/ack word stream.
// A running XOR checksum of the accepted words is kept for the current pass.
module result_streamer #(
  parameter int n     = 4,
  parameter int n_len = $clog2(n)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul_done,
  output logic [n_len-1:0] rd_i,
  output logic [n_len-1:0] rd_j,
  input  logic [31:0]      rd_data,
  output logic [31:0]      out_data,
  output logic [n_len-1:0] out_i,
  output logic [n_len-1:0] out_j,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             out_last,
  output logic             busy,
  output logic             finished,
  output logic [31:0]      checksum
);

  localparam logic [n_len-1:0] LAST_IDX = n_len'(n - 1);
  localparam logic [n_len-1:0] IDX_ONE  = n_len'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    ISSUE,
    PRESENT
  } state_t;

  state_t state, state_next;
  logic   at_last;

  // Comparing against n-1 (not all-ones) keeps non-power-of-two sizes wrapping correctly.
  assign at_last = (rd_i == LAST_IDX) && (rd_j == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start)    state_next = WAIT_DONE;
      WAIT_DONE: if (mul_done) state_next = ISSUE;
      ISSUE:                   state_next = PRESENT;
      PRESENT: begin
        if (out_ack) state_next = at_last ? IDLE : ISSUE;
      end
      default:                 state_next = IDLE;
    endcase
  end

  // Read address, output word register and pass bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_i     <= '0;
      rd_j     <= '0;
      out_data <= '0;
      out_i    <= '0;
      out_j    <= '0;
      out_stb  <= 1'b0;
      out_last <= 1'b0;
      finished <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_i     <= '0;
            rd_j     <= '0;
            checksum <= '0;
            finished <= 1'b0;
          end
        end
        ISSUE: begin
          out_data <= rd_data;
          out_i    <= rd_i;
          out_j    <= rd_j;
          out_stb  <= 1'b1;
          out_last <= at_last;
        end
        PRESENT: begin
          // Output word is frozen here; rd_data is not looked at until the next ISSUE.
          if (out_ack) begin
            out_stb  <= 1'b0;
            out_last <= 1'b0;
            checksum <= checksum ^ out_data;
            if (at_last) begin
              rd_i     <= '0;
              rd_j     <= '0;
              finished <= 1'b1;
            end else if (rd_j == LAST_IDX) begin
              rd_j <= '0;
              rd_i <= rd_i + IDX_ONE;
            end else begin
              rd_j <= rd_j + IDX_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer (n=3): queue-based model of the row-major drain,
// checked every cycle the strobe is up, plus hand-computed pass results.
module tb_result_streamer;

  localparam int N  = 3;
  localparam int NL = $clog2(N);

  logic          clk, rst, start, mul_done, out_ack;
  logic [NL-1:0] rd_i, rd_j, out_i, out_j;
  logic [31:0]   rd_data, out_data, checksum;
  logic          out_stb, out_last, busy, finished;

  logic [31:0] mat [0:N-1][0:N-1];

  typedef struct {
    logic [31:0] d;
    int          i;
    int          j;
  } elem_t;

  elem_t       exp_q[$];
  logic [31:0] model_cs;
  int          xfers;
  int          total  = 0;
  int          passed = 0;

  result_streamer #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mul_done(mul_done),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data),
    .out_data(out_data), .out_i(out_i), .out_j(out_j),
    .out_stb(out_stb), .out_ack(out_ack), .out_last(out_last),
    .busy(busy), .finished(finished), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rd_data = 32'h0;
    if (int'(rd_i) < N && int'(rd_j) < N) rd_data = mat[rd_i][rd_j];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every presented word must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst && out_stb) begin
      check("word_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_i", 32'(out_i), 32'(exp_q[0].i));
        check("out_j", 32'(out_j), 32'(exp_q[0].j));
        check("out_last", 32'(out_last), 32'(exp_q[0].i == N-1 && exp_q[0].j == N-1));
        check("checksum_run", checksum, model_cs);
        if (out_ack) begin
          model_cs = model_cs ^ exp_q[0].d;
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic fill_seq();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = 32'(i*N + j + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = $urandom;
  endtask

  task automatic do_start();
    exp_q.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_q.push_back('{mat[i][j], i, j});
    model_cs = 32'h0;
    xfers    = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_random_ack(input int bound);
    int k;
    k = 0;
    while (!finished && k < bound) begin
      out_ack = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_ack = 1'b1;
  endtask

  task automatic end_of_pass(input string tag);
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_xfers"}, 32'(xfers), 32'(N*N));
    check({tag, "_checksum"}, checksum, model_cs);
    check({tag, "_stb_low"}, 32'(out_stb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, last_rise, k;
    logic prev;
    rst = 1'b1; start = 1'b0; mul_done = 1'b0; out_ack = 1'b0;
    model_cs = 32'h0; xfers = 0;
    fill_seq();
    #3;
    check("rst_stb", 32'(out_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_addr", 32'({rd_i, rd_j}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Sequential matrix, ack held high, stray start during PRESENT.
    mul_done = 1'b1; out_ack = 1'b1;
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    cyc = 0; last_rise = -1; prev = 1'b0;
    while (!finished && cyc < 100) begin
      tick();
      cyc++;
      start = 1'b0;
      if (out_stb && !prev) begin
        if (last_rise >= 0) check("stb_period", 32'(cyc - last_rise), 32'd2);
        else begin
          check("first_stb_latency", 32'(cyc), 32'd2);
          check("first_word", out_data, 32'd1);
        end
        last_rise = cyc;
        check("last_only_on_9", 32'(out_last), 32'(out_data == 32'd9));
        if (out_i == 2'd1 && out_j == 2'd0) start = 1'b1;
      end
      prev = out_stb;
    end
    start = 1'b0;
    end_of_pass("seq");
    check("seq_checksum_lit", checksum, 32'd1);
    tick();
    check("finished_sticky", 32'(finished), 32'd1);

    // mul_done held low, then random ack with mul_done dropping mid-pass.
    fill_rand();
    mul_done = 1'b0;
    do_start();
    check("start_clears_finished", 32'(finished), 32'd0);
    repeat (10) begin
      tick();
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_stb", 32'(out_stb), 32'd0);
    end
    mul_done = 1'b1;
    tick();
    check("issue_no_stb", 32'(out_stb), 32'd0);
    tick();
    check("stream_begins", 32'(out_stb), 32'd1);
    mul_done = 1'b0;
    run_random_ack(400);
    end_of_pass("rand");

    // Backpressure on word 2 while rd_data is disturbed.
    fill_seq();
    mul_done = 1'b1; out_ack = 1'b1;
    do_start();
    k = 0;
    while (!(out_stb && out_i == 2'd0 && out_j == 2'd1) && k < 20) begin
      tick();
      k++;
    end
    check("word2_seen", 32'(k < 20), 32'd1);
    out_ack = 1'b0;
    repeat (5) begin
      mat[0][1] = $urandom;
      tick();
      check("bp_stb", 32'(out_stb), 32'd1);
      check("bp_data", out_data, 32'd2);
    end
    mat[0][1] = 32'd2;
    out_ack = 1'b1;
    k = 0;
    while (!finished && k < 100) begin
      tick();
      k++;
    end
    end_of_pass("bp");
    check("bp_checksum_lit", checksum, 32'd1);

    // Asynchronous reset after two transfers, then a fresh full pass.
    fill_rand();
    do_start();
    k = 0;
    while (xfers < 2 && k < 30) begin
      tick();
      k++;
    end
    check("two_xfers", 32'(xfers), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_stb", 32'(out_stb), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_checksum", checksum, 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_idx", 32'({rd_i, rd_j, out_i, out_j}), 32'd0);
    exp_q.delete();
    model_cs = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    do_start();
    run_random_ack(400);
    end_of_pass("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
